// File: rtl/page_cache_pkg.sv
// Shared types and width helpers for the parametrised page cache front end.
package page_cache_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        LOOKUP = 3'd2,
        ACCESS = 3'd3,
        FILL   = 3'd4
    } state_e;

    function automatic int page_width(input int lo_w, input int hi_w, input int ofs_w);
        return lo_w + hi_w - ofs_w;
    endfunction

    function automatic int slot_width(input int entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/page_cache_tags.sv
// Fully associative tag table: parallel compare, lowest-index hit, victim choice
// (first invalid slot, else round-robin) plus install and invalidate-all.
module page_cache_tags
    import page_cache_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int PAGE_W  = 14,
    parameter int PRELOAD = 1,
    localparam int SLOT_W = slot_width(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PAGE_W-1:0] lookup_page,
    output logic              hit,
    output logic [SLOT_W-1:0] hit_slot,
    output logic [SLOT_W-1:0] victim_slot,
    input  logic              install,
    input  logic [SLOT_W-1:0] install_slot,
    input  logic [PAGE_W-1:0] install_page,
    input  logic              inv_all
);

    logic [PAGE_W-1:0]  tag_q [ENTRIES];
    logic [PAGE_W-1:0]  tag_d [ENTRIES];
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] match;
    logic [SLOT_W-1:0]  rr_q, rr_d;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
            assign match[gi] = valid_q[gi] && (tag_q[gi] == lookup_page);
        end
    endgenerate

    // Descending scans so the lowest matching / lowest invalid index wins.
    always_comb begin
        hit         = |match;
        hit_slot    = '0;
        victim_slot = rr_q;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_slot = SLOT_W'(i);
            end
            if (!valid_q[i]) begin
                victim_slot = SLOT_W'(i);
            end
        end
    end

    // The pointer only moves when a live mapping is displaced.
    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        if (install) begin
            tag_d[install_slot]   = install_page;
            valid_d[install_slot] = 1'b1;
            if (valid_q[install_slot]) begin
                rr_d = rr_q + 1'b1;
            end
        end
        if (inv_all) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= (PRELOAD != 0) ? PAGE_W'(i) : '0;
            end
            valid_q <= (PRELOAD != 0) ? '1 : '0;
            rr_q    <= '0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: rtl/page_cache_mmu.sv
// Bus-side page cache front end: latches {bank,addr}, looks the page up, runs the
// fill handshake on a miss and issues a single-cycle SRAM enable per bus access.
module page_cache_mmu
    import page_cache_pkg::*;
#(
    parameter int LO_W        = 16,
    parameter int HI_W        = 8,
    parameter int OFS_W       = 10,
    parameter int ENTRIES     = 4,
    parameter int SRAM_ADDR_W = 6,
    parameter int PRELOAD     = 1,
    parameter int CNT_W       = 16,
    localparam int PAGE_W     = page_width(LO_W, HI_W, OFS_W),
    localparam int SLOT_W     = slot_width(ENTRIES)
) (
    input  logic                   fpgaClk,
    input  logic                   fpgaRst_n,
    input  logic [LO_W-1:0]        a,
    input  logic [HI_W-1:0]        d,
    output logic                   phi2,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_ce,
    output logic                   fill_req,
    output logic [PAGE_W-1:0]      fill_page,
    output logic [SLOT_W-1:0]      fill_slot,
    input  logic                   fill_ack,
    input  logic                   inv,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [CNT_W-1:0]       miss_cnt
);

    localparam int ADDR_W = LO_W + HI_W;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic                   sram_ce_q, sram_ce_d;
    logic                   fill_req_q, fill_req_d;
    logic [PAGE_W-1:0]      fill_page_q, fill_page_d;
    logic [SLOT_W-1:0]      fill_slot_q, fill_slot_d;
    logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;
    logic                   inv_pend_q, inv_pend_d;

    logic [PAGE_W-1:0]      lookup_page;
    logic                   tag_hit;
    logic [SLOT_W-1:0]      hit_slot, victim_slot;
    logic                   install, inv_all;

    assign lookup_page = addr_q[ADDR_W-1:OFS_W];

    page_cache_tags #(
        .ENTRIES (ENTRIES),
        .PAGE_W  (PAGE_W),
        .PRELOAD (PRELOAD)
    ) u_tags (
        .clk          (fpgaClk),
        .rst_n        (fpgaRst_n),
        .lookup_page  (lookup_page),
        .hit          (tag_hit),
        .hit_slot     (hit_slot),
        .victim_slot  (victim_slot),
        .install      (install),
        .install_slot (fill_slot_q),
        .install_page (fill_page_q),
        .inv_all      (inv_all)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sram_addr_d = sram_addr_q;
        fill_req_d  = fill_req_q;
        fill_page_d = fill_page_q;
        fill_slot_d = fill_slot_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        inv_pend_d  = inv_pend_q | inv;
        install     = 1'b0;
        inv_all     = 1'b0;
        unique case (state_q)
            IDLE:   state_d = LATCH;
            LATCH: begin
                addr_d  = {d, a};
                state_d = LOOKUP;
            end
            LOOKUP: begin
                if (tag_hit) begin
                    state_d     = ACCESS;
                    sram_addr_d = SRAM_ADDR_W'(hit_slot);
                    if (hit_cnt_q != {CNT_W{1'b1}}) begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                end else begin
                    state_d     = FILL;
                    fill_req_d  = 1'b1;
                    fill_page_d = lookup_page;
                    fill_slot_d = victim_slot;
                    if (miss_cnt_q != {CNT_W{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end
            FILL: begin
                if (fill_ack) begin
                    install     = 1'b1;
                    fill_req_d  = 1'b0;
                    sram_addr_d = SRAM_ADDR_W'(fill_slot_q);
                    state_d     = ACCESS;
                end
            end
            ACCESS: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Invalidation waits for the bus cycle to end so an in-flight access keeps its slot.
        if (state_q == IDLE || state_d == IDLE) begin
            inv_all    = inv_pend_q | inv;
            inv_pend_d = 1'b0;
        end
        sram_ce_d = (state_d == ACCESS);
    end

    always_ff @(posedge fpgaClk) begin
        if (!fpgaRst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            sram_addr_q <= '0;
            sram_ce_q   <= 1'b0;
            fill_req_q  <= 1'b0;
            fill_page_q <= '0;
            fill_slot_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            inv_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sram_addr_q <= sram_addr_d;
            sram_ce_q   <= sram_ce_d;
            fill_req_q  <= fill_req_d;
            fill_page_q <= fill_page_d;
            fill_slot_q <= fill_slot_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            inv_pend_q  <= inv_pend_d;
        end
    end

    assign phi2      = (state_q == LOOKUP) || (state_q == FILL) || (state_q == ACCESS);
    assign sram_addr = sram_addr_q;
    assign sram_ce   = sram_ce_q;
    assign fill_req  = fill_req_q;
    assign fill_page = fill_page_q;
    assign fill_slot = fill_slot_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule
